prog_mem_loadable: RTL

- Parametrised, synchronous instruction memory for the processor core; next generation of the fixed combinational program ROM.
- Adds configurable word width and depth, a registered fetch port with a valid flag, and a word-serial program loader.
- The loader lets test programs be written at run time instead of being hard-coded.
- Sits between the loader source (bench or UART bridge) and the core's fetch stage.

---
 rtl/prog_mem_loadable.sv | 131 +++++++++++++
 1 files changed

// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable: parametrised instruction memory with a registered fetch
// port and a word-serial run-time program loader (RUN / LOAD states).
module prog_mem_loadable #(
    parameter int unsigned           DATA_WIDTH = 21,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  addr_err,
    input  logic                  load_start,
    input  logic                  load_we,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  busy,
    output logic                  load_ovf,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    mem_we;
    logic                    fetch_in_range;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Contents survive reset; the initial value only seeds simulation and FPGA init.
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH] = '{default: FILL_WORD};

    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_C);
    assign rd_word        = mem_q[fetch_addr[IDX_W-1:0]];

    // Next-state logic for the loader FSM, counter, and the registered fetch port.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_start) begin
                    // load_start beats a concurrent fetch: no fetch is accepted
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (fetch_en) begin
                    valid_d = 1'b1;
                    if (fetch_in_range) begin
                        instr_d = rd_word;
                        err_d   = 1'b0;
                    end else begin
                        instr_d = FILL_WORD;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    // restart discards any word presented in the same cycle
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (load_we) begin
                    if (cnt_q < DEPTH_C) begin
                        mem_we = 1'b1;
                        cnt_d  = cnt_q + ONE_C;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Register FSM state and all outputs; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            instr_q <= FILL_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Loader write port; a write coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[cnt_q[IDX_W-1:0]] <= load_data;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign addr_err    = err_q;
    assign busy        = (state_q == ST_LOAD);
    assign load_ovf    = ovf_q;
    assign word_count  = cnt_q;

endmodule
